// File: rtl/force_overlay_pkg.sv
`default_nettype none
// ============================================================================
// force_overlay_pkg : shared types and merge helper for the force overlay
// Revision: 1.0
// ============================================================================
package force_overlay_pkg;

    localparam int MAX_W = 512;

    typedef enum logic [1:0] {
        OP_FORCE       = 2'b00,
        OP_RELEASE     = 2'b01,
        OP_RELEASE_ALL = 2'b10,
        OP_RSVD        = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_WAIT  = 2'b01,
        ST_APPLY = 2'b10
    } state_e;

    // Forced bits take the overlay value, released bits pass the driven value.
    function automatic logic [MAX_W-1:0] merge(
        input logic [MAX_W-1:0] din,
        input logic [MAX_W-1:0] val,
        input logic [MAX_W-1:0] mask
    );
        return (din & ~mask) | (val & mask);
    endfunction

endpackage
`default_nettype wire

// File: rtl/force_overlay_chan.sv
`default_nettype none
// ============================================================================
// force_overlay_chan : per-channel mask/value registers and overlay merge
// Revision: 1.0
// ============================================================================
module force_overlay_chan
    import force_overlay_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             apply,
    input  op_e              op,
    input  logic [WIDTH-1:0] cmd_mask,
    input  logic [WIDTH-1:0] cmd_value,
    input  logic [WIDTH-1:0] sig_in,
    output logic [WIDTH-1:0] sig_out,
    output logic [WIDTH-1:0] mask,
    output logic             forced
);

    logic [WIDTH-1:0] r_mask;
    logic [WIDTH-1:0] r_val;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mask <= '0;
            r_val  <= '0;
        end else if (apply) begin
            case (op)
                OP_FORCE: begin
                    r_mask <= r_mask | cmd_mask;
                    r_val  <= (r_val & ~cmd_mask) | (cmd_value & cmd_mask);
                end
                OP_RELEASE:     r_mask <= r_mask & ~cmd_mask;
                OP_RELEASE_ALL: r_mask <= '0;
                default: ;
            endcase
        end
    end

    // Zero-latency path from sig_in; only mask/val are registered.
    assign sig_out = WIDTH'(merge(MAX_W'(sig_in), MAX_W'(r_val), MAX_W'(r_mask)));
    assign mask    = r_mask;
    assign forced  = |r_mask;

endmodule
`default_nettype wire

// File: rtl/force_overlay_ctrl.sv
`default_nettype none
// ============================================================================
// force_overlay_ctrl : command FSM, delay counter and readback for overlay
// Revision: 1.0
// ============================================================================
module force_overlay_ctrl
    import force_overlay_pkg::*;
#(
    parameter int WIDTH    = 64,
    parameter int CHANNELS = 4,
    parameter int DELAY_W  = 8,
    parameter int CHW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [1:0]                cmd_op,
    input  logic [CHW-1:0]            cmd_chan,
    input  logic [WIDTH-1:0]          cmd_mask,
    input  logic [WIDTH-1:0]          cmd_value,
    input  logic [DELAY_W-1:0]        cmd_delay,
    input  logic                      cmd_abort,
    output logic                      done,
    output logic                      err,
    input  logic [CHANNELS*WIDTH-1:0] sig_in,
    output logic [CHANNELS*WIDTH-1:0] sig_out,
    output logic [CHANNELS-1:0]       forced,
    input  logic [CHW-1:0]            rd_chan,
    output logic [WIDTH-1:0]          rd_data,
    output logic [WIDTH-1:0]          rd_mask
);

    state_e             r_state;
    state_e             w_next;
    op_e                r_op;
    logic [CHW-1:0]     r_chan;
    logic [WIDTH-1:0]   r_mask;
    logic [WIDTH-1:0]   r_value;
    logic               r_bad;
    logic [DELAY_W-1:0] r_cnt;
    logic               w_accept;
    logic               w_bad;
    logic [CHANNELS-1:0] w_apply;
    logic [WIDTH-1:0]   w_mask [CHANNELS];
    logic [WIDTH-1:0]   w_rd_data;
    logic [WIDTH-1:0]   w_rd_mask;

    assign w_accept = cmd_valid & cmd_ready;
    // RELEASE_ALL ignores the channel field, so it can never be out of range.
    assign w_bad = (op_e'(cmd_op) == OP_RSVD) |
                   ((op_e'(cmd_op) != OP_RELEASE_ALL) &
                    ({1'b0, cmd_chan} >= (CHW+1)'(CHANNELS)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        cmd_ready = 1'b0;
        done      = 1'b0;
        err       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                cmd_ready = ~rst;
                if (cmd_valid && !rst) begin
                    w_next = (cmd_delay == '0) ? ST_APPLY : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cmd_abort) begin
                    w_next = ST_IDLE;
                end else if (r_cnt == DELAY_W'(1)) begin
                    w_next = ST_APPLY;
                end
            end
            ST_APPLY: begin
                done   = ~r_bad;
                err    = r_bad;
                w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op    <= OP_FORCE;
            r_chan  <= '0;
            r_mask  <= '0;
            r_value <= '0;
            r_bad   <= 1'b0;
            r_cnt   <= '0;
        end else if (w_accept) begin
            r_op    <= op_e'(cmd_op);
            r_chan  <= cmd_chan;
            r_mask  <= cmd_mask;
            r_value <= cmd_value;
            r_bad   <= w_bad;
            r_cnt   <= cmd_delay;
        end else if (r_state == ST_WAIT && !cmd_abort && r_cnt != DELAY_W'(1)) begin
            r_cnt <= r_cnt - DELAY_W'(1);
        end
    end

    for (genvar k = 0; k < CHANNELS; k++) begin : g_chan
        assign w_apply[k] = (r_state == ST_APPLY) & ~r_bad &
                            ((r_op == OP_RELEASE_ALL) | (r_chan == CHW'(k)));

        force_overlay_chan #(
            .WIDTH (WIDTH)
        ) u_chan (
            .clk       (clk),
            .rst       (rst),
            .apply     (w_apply[k]),
            .op        (r_op),
            .cmd_mask  (r_mask),
            .cmd_value (r_value),
            .sig_in    (sig_in[k*WIDTH +: WIDTH]),
            .sig_out   (sig_out[k*WIDTH +: WIDTH]),
            .mask      (w_mask[k]),
            .forced    (forced[k])
        );
    end

    // Unmatched selects (rd_chan >= CHANNELS) fall through to zero.
    always_comb begin
        w_rd_data = '0;
        w_rd_mask = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (rd_chan == CHW'(k)) begin
                w_rd_data = sig_out[k*WIDTH +: WIDTH];
                w_rd_mask = w_mask[k];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data <= '0;
            rd_mask <= '0;
        end else begin
            rd_data <= w_rd_data;
            rd_mask <= w_rd_mask;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_force_overlay_ctrl.sv
`default_nettype none
// ============================================================================
// tb_force_overlay_ctrl : scoreboard bench for the force overlay controller
// Revision: 1.0
// ============================================================================
module tb_force_overlay_ctrl;

    localparam int WIDTH    = 64;
    localparam int CHANNELS = 4;
    localparam int DELAY_W  = 8;
    localparam int CHW      = 3;
    localparam logic [1:0] C_FORCE = 2'b00, C_REL = 2'b01, C_RALL = 2'b10, C_RSVD = 2'b11;
    localparam logic [1:0] C_RSP_NONE = 2'b00, C_RSP_DONE = 2'b10, C_RSP_ERR = 2'b01;
    localparam logic [63:0] C_ONES = '1;
    localparam logic [63:0] C_AAAA = 64'hAAAAAAAAAAAAAAAA;

    logic                      clk = 1'b0;
    logic                      rst;
    logic                      cmd_valid;
    logic                      cmd_ready;
    logic [1:0]                cmd_op;
    logic [CHW-1:0]            cmd_chan;
    logic [WIDTH-1:0]          cmd_mask;
    logic [WIDTH-1:0]          cmd_value;
    logic [DELAY_W-1:0]        cmd_delay;
    logic                      cmd_abort;
    logic                      done;
    logic                      err;
    logic [CHANNELS*WIDTH-1:0] sig_in;
    logic [CHANNELS*WIDTH-1:0] sig_out;
    logic [CHANNELS-1:0]       forced;
    logic [CHW-1:0]            rd_chan;
    logic [WIDTH-1:0]          rd_data;
    logic [WIDTH-1:0]          rd_mask;

    int n_checks = 0;
    int n_errors = 0;
    logic [1:0]  sb_q [$];
    logic [63:0] m_mask [CHANNELS];
    logic [63:0] m_val  [CHANNELS];

    force_overlay_ctrl #(
        .WIDTH (WIDTH), .CHANNELS (CHANNELS), .DELAY_W (DELAY_W), .CHW (CHW)
    ) dut (
        .clk (clk), .rst (rst),
        .cmd_valid (cmd_valid), .cmd_ready (cmd_ready), .cmd_op (cmd_op),
        .cmd_chan (cmd_chan), .cmd_mask (cmd_mask), .cmd_value (cmd_value),
        .cmd_delay (cmd_delay), .cmd_abort (cmd_abort),
        .done (done), .err (err),
        .sig_in (sig_in), .sig_out (sig_out), .forced (forced),
        .rd_chan (rd_chan), .rd_data (rd_data), .rd_mask (rd_mask)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Every done/err pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && (done || err)) begin
            if (sb_q.size() == 0) begin
                check("spurious_rsp", {62'b0, done, err}, 64'd0);
            end else begin
                check("rsp_kind", {62'b0, done, err}, {62'b0, sb_q.pop_front()});
            end
        end
    end

    function automatic void model_apply(input logic [1:0] op, input int ch,
                                        input logic [63:0] mask, input logic [63:0] value);
        case (op)
            C_FORCE: begin
                m_mask[ch] = m_mask[ch] | mask;
                m_val[ch]  = (m_val[ch] & ~mask) | (value & mask);
            end
            C_REL:  m_mask[ch] = m_mask[ch] & ~mask;
            C_RALL: for (int k = 0; k < CHANNELS; k++) m_mask[k] = '0;
            default: ;
        endcase
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < CHANNELS; k++) begin
            m_mask[k] = '0;
            m_val[k]  = '0;
        end
    endfunction

    task automatic check_all();
        logic [CHANNELS-1:0] f;
        for (int k = 0; k < CHANNELS; k++) begin
            check($sformatf("sig_out_ch%0d", k), sig_out[k*WIDTH +: WIDTH],
                  (sig_in[k*WIDTH +: WIDTH] & ~m_mask[k]) | (m_val[k] & m_mask[k]));
            f[k] = |m_mask[k];
        end
        check("forced", 64'(forced), 64'(f));
    endtask

    // Drives one command; returns #1 into the cycle after the accept edge.
    task automatic send(input logic [1:0] op, input int ch, input logic [63:0] mask,
                        input logic [63:0] value, input int delay, input logic [1:0] rsp);
        int n = 0;
        @(posedge clk); #1;
        while (!cmd_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!cmd_ready) check("ready_timeout", 64'd0, 64'd1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_chan  = CHW'(ch);
        cmd_mask  = mask;
        cmd_value = value;
        cmd_delay = DELAY_W'(delay);
        if (rsp != C_RSP_NONE) sb_q.push_back(rsp);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    // Waits for the response, then lands in the cycle where the change is visible.
    task automatic finish_cmd();
        int n = 0;
        while (sb_q.size() != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        if (sb_q.size() != 0) begin
            check("rsp_timeout", 64'(sb_q.size()), 64'd0);
            sb_q.delete();
        end
        @(negedge clk);
        check_all();
    endtask

    initial begin
        rst = 1'b1;
        cmd_valid = 1'b0; cmd_op = '0; cmd_chan = '0; cmd_mask = '0;
        cmd_value = '0; cmd_delay = '0; cmd_abort = 1'b0; rd_chan = '0;
        sig_in = {64'h0123456789ABCDEF, C_AAAA, C_AAAA, C_AAAA};
        model_reset();

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("ready_in_rst", 64'(cmd_ready), 64'd0);
        check("rst_sig_out_ch0", sig_out[63:0], C_AAAA);
        check("rst_forced", 64'(forced), 64'd0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", 64'(cmd_ready), 64'd1);
        check("rst_rd_data", rd_data, 64'd0);
        check("rst_rd_mask", rd_mask, 64'd0);

        // Full force ch1, delay 0
        send(C_FORCE, 1, C_ONES, 64'h5555555555555555, 0, C_RSP_DONE);
        @(negedge clk);
        check("f1_done_c1", 64'(done), 64'd1);
        check("f1_unchanged_c1", sig_out[127:64], C_AAAA);
        model_apply(C_FORCE, 1, C_ONES, 64'h5555555555555555);
        @(negedge clk);
        check("f1_sig_out", sig_out[127:64], 64'h5555555555555555);
        check("f1_forced", 64'(forced), 64'b0010);
        rd_chan = 3'd1;
        @(negedge clk);
        check("rd_data_ch1", rd_data, 64'h5555555555555555);
        check("rd_mask_ch1", rd_mask, C_ONES);
        rd_chan = 3'd6;
        @(negedge clk);
        check("rd_data_oob", rd_data, 64'd0);
        check("rd_mask_oob", rd_mask, 64'd0);

        // Partial force then partial release on ch2
        send(C_FORCE, 2, 64'h00000000FFFFFFFF, 64'h55555555, 0, C_RSP_DONE);
        model_apply(C_FORCE, 2, 64'h00000000FFFFFFFF, 64'h55555555);
        finish_cmd();
        check("part_force_ch2", sig_out[191:128], 64'hAAAAAAAA55555555);
        send(C_REL, 2, 64'h0000FFFF, 64'd0, 0, C_RSP_DONE);
        model_apply(C_REL, 2, 64'h0000FFFF, 64'd0);
        finish_cmd();
        check("part_rel_ch2", sig_out[191:128], 64'hAAAAAAAA5555AAAA);

        // Empty mask is legal and changes nothing
        send(C_FORCE, 1, 64'd0, C_ONES, 0, C_RSP_DONE);
        finish_cmd();

        // Delay 5 on ch0: unchanged through c0+6, done at c0+6, changed at c0+7
        send(C_FORCE, 0, C_ONES, 64'hDEADBEEFCAFEF00D, 5, C_RSP_DONE);
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            check($sformatf("dly_hold_c%0d", i), sig_out[63:0], C_AAAA);
            check($sformatf("dly_done_c%0d", i), 64'(done), 64'(i == 6));
        end
        model_apply(C_FORCE, 0, C_ONES, 64'hDEADBEEFCAFEF00D);
        @(negedge clk);
        check("dly_applied", sig_out[63:0], 64'hDEADBEEFCAFEF00D);
        check_all();

        // Abort at c0+3 during a delay-5 command
        send(C_FORCE, 3, C_ONES, 64'hFFFF0000FFFF0000, 5, C_RSP_NONE);
        @(posedge clk);
        @(posedge clk); #1 cmd_abort = 1'b1;
        @(posedge clk); #1 cmd_abort = 1'b0;
        @(negedge clk);
        check("abort_ready", 64'(cmd_ready), 64'd1);
        repeat (8) @(negedge clk);
        check_all();

        // Rejected commands: reserved op and out-of-range channel
        send(C_RSVD, 0, C_ONES, 64'd0, 0, C_RSP_ERR);
        @(negedge clk);
        check("rsvd_err", 64'(err), 64'd1);
        check("rsvd_no_done", 64'(done), 64'd0);
        finish_cmd();
        send(C_FORCE, 5, C_ONES, 64'd0, 0, C_RSP_ERR);
        @(negedge clk);
        check("badch_err", 64'(err), 64'd1);
        check("badch_no_done", 64'(done), 64'd0);
        finish_cmd();

        // RELEASE_ALL ignores the channel field
        send(C_RALL, 5, 64'd0, 64'd0, 0, C_RSP_DONE);
        model_apply(C_RALL, 0, 64'd0, 64'd0);
        finish_cmd();
        check("rall_forced", 64'(forced), 64'd0);

        // Async reset during WAIT discards the command
        send(C_FORCE, 1, C_ONES, 64'h5555555555555555, 0, C_RSP_DONE);
        model_apply(C_FORCE, 1, C_ONES, 64'h5555555555555555);
        finish_cmd();
        send(C_FORCE, 2, C_ONES, 64'd0, 20, C_RSP_NONE);
        repeat (3) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("arst_forced", 64'(forced), 64'd0);
        check("arst_sig_out_ch1", sig_out[127:64], C_AAAA);
        model_reset();
        @(posedge clk); #1 rst = 1'b0;
        repeat (30) @(negedge clk);
        check_all();
        check("arst_ready", 64'(cmd_ready), 64'd1);

        check("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/force_overlay_ctrl.md
Name: force_overlay_ctrl

Overview:
- Multi-channel hardware force/release overlay; the RTL counterpart of simulator force semantics: forced bits replace the driven value, and released bits fall back to it.
- Sits between design signals (sig_in) and their consumers (sig_out).
- Accepts FORCE / RELEASE / RELEASE_ALL commands with per-bit masks, optional cycle delay and abort.
- Provides registered readback of the effective value and mask per channel, matching force-read semantics.

Parameters:
WIDTH, 64, bits per channel (1..512)
CHANNELS, 4, number of overlaid signals (1..32)
DELAY_W, 8, width of the command delay counter
CHW, $clog2(CHANNELS) min 1, derived channel-index width

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
cmd_valid  in  1  command offered
cmd_ready  out  1  command accepted when valid&ready
cmd_op  in  2  00 FORCE, 01 RELEASE, 10 RELEASE_ALL, 11 reserved
cmd_chan  in  CHW  target channel
cmd_mask  in  WIDTH  bits affected
cmd_value  in  WIDTH  force value (FORCE only)
cmd_delay  in  DELAY_W  cycles to wait before applying
cmd_abort  in  1  cancel a command waiting in WAIT
done  out  1  one-cycle pulse: command applied
err  out  1  one-cycle pulse: command rejected
sig_in  in  CHANNELS*WIDTH  driven values, channel k at [k*WIDTH +: WIDTH]
sig_out  out  CHANNELS*WIDTH  effective values
forced  out  CHANNELS  bit k = |mask[k]
rd_chan  in  CHW  readback select
rd_data  out  WIDTH  registered effective value of rd_chan
rd_mask  out  WIDTH  registered mask of rd_chan

Behaviour:
- Reset (async assert, sync release): all mask and val registers 0; FSM IDLE; done=err=0; rd_data=rd_mask=0; cmd_ready=0 while rst is high.
- While mask=0: sig_out=sig_in (combinational).
- Merge per channel k: sig_out[k] = (sig_in[k] & ~mask[k]) | (val[k] & mask[k]). This path is combinational from sig_in; zero latency.
- FSM states:
  - IDLE: cmd_ready=1. On accept, latch op/chan/mask/value and compute bad = (op==11) | (op!=10 & chan>=CHANNELS). If cmd_delay==0 go to APPLY; else go to WAIT with cnt=cmd_delay.
  - WAIT: cmd_ready=0. If cmd_abort: go to IDLE with no done/err and no effect (abort takes priority over expiry). Else if cnt==1: go to APPLY. Else cnt--.
  - APPLY: cmd_ready=0, one cycle. If bad: err=1, no register change. Else done=1 and registers update at the end of the cycle. Next state is IDLE.
- Register updates:
  - FORCE: mask|=cmd_mask; val=(val&~cmd_mask)|(cmd_value&cmd_mask). A partial force merges with bits already forced.
  - RELEASE: mask&=~cmd_mask. val is kept, but it is don't-care where mask=0.
  - RELEASE_ALL: every channel's mask=0; cmd_chan and cmd_mask are ignored.
- cmd_mask=0 is legal: done pulses, no change.
- Latency: accept at cycle c0 → APPLY at c0+1+d → sig_out, forced and readback source reflect the change from cycle c0+2+d.
- Only one command is in flight; there is no queue. Back-to-back accepts are at most one per 2 cycles (delay 0).
- cmd_abort outside WAIT is ignored.
- cnt saturates at no value. The maximum delay is 2^DELAY_W-1 cycles.
- Readback: rd_data/rd_mask are registered one cycle after rd_chan and taken from current sig_out and mask. rd_chan>=CHANNELS returns 0/0.
- Reset mid-WAIT or mid-APPLY: the command is discarded and no done/err is produced.

Decomposition:
- Package force_overlay_pkg holds: op enum (OP_FORCE, OP_RELEASE, OP_RELEASE_ALL, OP_RSVD); FSM state enum (ST_IDLE, ST_WAIT, ST_APPLY); function merge(in, val, mask).
- Sub-module force_overlay_chan, instantiated CHANNELS times via generate. It holds the mask/val registers, performs the merge, takes a per-channel apply strobe plus op/mask/value, and outputs sig_out slice, mask and forced bit.
- The top holds the FSM, delay counter, error check and readback mux.

Test Plan:
- Reset then idle (sig_in ch0=64'hAAAAAAAAAAAAAAAA) → sig_out ch0=64'hAAAA..., forced=0, cmd_ready=1 one cycle after rst deasserts.
- FORCE ch1, mask all-ones, value 64'h5555555555555555, delay 0, accepted at c0 → done at c0+1; sig_out ch1=64'h5555... from c0+2; forced=4'b0010; rd_chan=1 gives rd_data=64'h5555..., rd_mask=all-ones one cycle later.
- Partial force ch2 (sig_in=64'hAAAA...), mask 64'h00000000FFFFFFFF, value 64'h55555555 → sig_out=64'hAAAAAAAA55555555. Then RELEASE mask 64'h0000FFFF → sig_out=64'hAAAAAAAA5555AAAA.
- FORCE ch0 with delay 5 accepted at c0 → sig_out unchanged through c0+6, changed at c0+7, done at c0+6. Repeat with cmd_abort at c0+3 → no done, no change, cmd_ready=1 at c0+4.
- Error cases: cmd_op=11, or cmd_chan=5 with CHANNELS=4 → err pulse at c0+1, done=0, masks unchanged. RELEASE_ALL with cmd_chan=5 → done and all forced=0.
- Async rst asserted mid-WAIT → immediate mask=0, sig_out=sig_in, no done after release of reset.
